// File: rtl/nand_seq_alu.sv
// Purpose: bit-serial logic unit; AND/OR/XOR/... built from one shared NAND gate, LSB first.
// Latency: WIDTH*S+1 cycles from accepted start to done (S = NAND steps per bit); illegal op 1 cycle.
// Backpressure: start is honoured only while idle; requests while busy are dropped, not queued.

module nand_g (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module nand_seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  localparam logic [2:0] OP_NAND = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [1:0] {SRC_A, SRC_B, SRC_T1, SRC_T2} src_t;
  typedef enum logic [1:0] {DST_T1, DST_T2, DST_Y} dst_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             t1;
  logic             t2;
  logic [2:0]       step_cnt;
  logic [BW-1:0]    bit_cnt;

  src_t sel_x;
  src_t sel_y;
  dst_t dst;
  logic gate_x;
  logic gate_y;
  logic gate_out;
  logic a_bit;
  logic b_bit;

  assign a_bit = a_q[bit_cnt];
  assign b_bit = b_q[bit_cnt];

  // NAND schedule: gate operand sources and destination for the current op/step.
  // The step whose destination is DST_Y is always the last step of a bit.
  always_comb begin
    sel_x = SRC_A;
    sel_y = SRC_B;
    dst   = DST_Y;
    case (op_q)
      OP_NAND: begin
        sel_x = SRC_A; sel_y = SRC_B; dst = DST_Y;
      end
      OP_AND: begin
        case (step_cnt)
          3'd0:    begin sel_x = SRC_A;  sel_y = SRC_B;  dst = DST_T1; end
          default: begin sel_x = SRC_T1; sel_y = SRC_T1; dst = DST_Y;  end
        endcase
      end
      OP_OR, OP_NOR: begin
        case (step_cnt)
          3'd0:    begin sel_x = SRC_A;  sel_y = SRC_A;  dst = DST_T1; end
          3'd1:    begin sel_x = SRC_B;  sel_y = SRC_B;  dst = DST_T2; end
          3'd2:    begin
            sel_x = SRC_T1; sel_y = SRC_T2;
            dst   = (op_q == OP_NOR) ? DST_T1 : DST_Y;
          end
          default: begin sel_x = SRC_T1; sel_y = SRC_T1; dst = DST_Y;  end
        endcase
      end
      OP_XOR, OP_XNOR: begin
        case (step_cnt)
          3'd0:    begin sel_x = SRC_A;  sel_y = SRC_B;  dst = DST_T1; end
          3'd1:    begin sel_x = SRC_A;  sel_y = SRC_T1; dst = DST_T2; end
          3'd2:    begin sel_x = SRC_B;  sel_y = SRC_T1; dst = DST_T1; end
          3'd3:    begin
            sel_x = SRC_T2; sel_y = SRC_T1;
            dst   = (op_q == OP_XNOR) ? DST_T1 : DST_Y;
          end
          default: begin sel_x = SRC_T1; sel_y = SRC_T1; dst = DST_Y;  end
        endcase
      end
      OP_NOTA: begin
        sel_x = SRC_A; sel_y = SRC_A; dst = DST_Y;
      end
      default: begin
        sel_x = SRC_A; sel_y = SRC_B; dst = DST_Y;
      end
    endcase
  end

  // Gate operand muxes from {a_i, b_i, t1, t2}.
  always_comb begin
    gate_x = a_bit;
    gate_y = b_bit;
    case (sel_x)
      SRC_A:   gate_x = a_bit;
      SRC_B:   gate_x = b_bit;
      SRC_T1:  gate_x = t1;
      default: gate_x = t2;
    endcase
    case (sel_y)
      SRC_A:   gate_y = a_bit;
      SRC_B:   gate_y = b_bit;
      SRC_T1:  gate_y = t1;
      default: gate_y = t2;
    endcase
  end

  nand_g u_nand (
    .a (gate_x),
    .b (gate_y),
    .y (gate_out)
  );

  // Controller: accept requests, run one NAND step per cycle, publish result with a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      t1       <= 1'b0;
      t2       <= 1'b0;
      step_cnt <= '0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op;
            result   <= '0;
            step_cnt <= '0;
            bit_cnt  <= '0;
            t1       <= 1'b0;
            t2       <= 1'b0;
            busy     <= 1'b1;
            if (op == OP_ILL) begin
              // Nothing to compute: report the error straight away with a zero result.
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= EXEC;
              err   <= 1'b0;
            end
          end
        end
        EXEC: begin
          case (dst)
            DST_T1: begin
              t1       <= gate_out;
              step_cnt <= step_cnt + 3'd1;
            end
            DST_T2: begin
              t2       <= gate_out;
              step_cnt <= step_cnt + 3'd1;
            end
            default: begin
              result[bit_cnt] <= gate_out;
              step_cnt        <= '0;
              if (bit_cnt == LAST_BIT) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          endcase
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand_seq_alu.sv
// Bench for nand_seq_alu: directed cases followed by random ops against a truth-level model.
// Latency and result are predicted from the op's step count and plain bitwise operators.
// Outputs are sampled on the falling edge; inputs change on the falling edge.

module tb_nand_seq_alu;

  localparam int W = 8;

  logic         clk;
  logic         clk_en;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] result;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  nand_seq_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  // Count every done pulse seen, so stray or duplicate pulses are noticed.
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the logic function itself, not the NAND decomposition.
  function automatic logic [W-1:0] ref_fn(input logic [2:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    case (o)
      3'd0:    return ~(x & y);
      3'd1:    return x & y;
      3'd2:    return x | y;
      3'd3:    return ~(x | y);
      3'd4:    return x ^ y;
      3'd5:    return ~(x ^ y);
      3'd6:    return ~x;
      default: return '0;
    endcase
  endfunction

  function automatic int steps(input logic [2:0] o);
    int s_tab [8] = '{1, 2, 3, 4, 4, 5, 1, 0};
    return s_tab[o];
  endfunction

  // Wait (bounded) for done; n = clock edges since the acceptance edge.
  task automatic wait_done(output int n);
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 300) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv);
    int n;
    int exp_n;
    logic [W-1:0] exp_r;
    logic exp_e;
    exp_e = (o == 3'b111);
    exp_r = ref_fn(o, av, bv);
    exp_n = exp_e ? 0 : W * steps(o);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 3'($urandom); a = W'($urandom); b = W'($urandom);
    wait_done(n);
    check({tag, " latency"}, n, exp_n);
    check({tag, " result"}, result, exp_r);
    check({tag, " err"}, err, exp_e);
    check({tag, " busy@done"}, busy, 1'b1);
    @(negedge clk);
    check({tag, " done pulse"}, done, 1'b0);
    check({tag, " busy idle"}, busy, 1'b0);
    check({tag, " err cleared"}, err, 1'b0);
    @(negedge clk);
    check({tag, " result held"}, result, exp_r);
  endtask

  initial begin
    int n;
    int d0;
    clk_en = 1'b0;
    rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;

    // 1: reset with the clock stopped clears outputs immediately.
    #3 rst = 1'b1;
    #1;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst err", err, 1'b0);
    check("rst result", result, 8'h00);
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 2-4: directed functions.
    run_op("and", 3'b001, 8'hF0, 8'hCC);
    run_op("xor", 3'b100, 8'hA5, 8'h0F);
    run_op("xnor", 3'b101, 8'hFF, 8'h00);
    run_op("nor", 3'b011, 8'h0F, 8'hF0);
    run_op("or", 3'b010, 8'h0F, 8'hF0);
    run_op("nota", 3'b110, 8'h3C, 8'h00);
    run_op("nand", 3'b000, 8'h5A, 8'h33);

    // 5: start while busy (in EXEC and in DONE) is ignored.
    @(negedge clk);
    d0 = done_cnt;
    start = 1'b1; op = 3'b000; a = 8'h00; b = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 300) begin
      if (n == 2) begin start = 1'b1; op = 3'b001; a = 8'hFF; b = 8'hFF; end
      if (n == 3) begin start = 1'b0; a = 8'h12; b = 8'h34; end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("busy-start latency", n, 8);
    check("busy-start result", result, 8'hFF);
    start = 1'b1; op = 3'b001; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    check("start in done ignored", busy, 1'b0);
    repeat (20) @(negedge clk);
    check("single done pulse", done_cnt - d0, 1);
    check("busy-start result held", result, 8'hFF);

    // 6: reset in the middle of EXEC, then an illegal op, then recovery.
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 8'hFF; b = 8'h00;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("mid-exec busy", busy, 1'b1);
    check("mid-exec partial result", result, 8'h07);
    #1 rst = 1'b1;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort err", err, 1'b0);
    check("abort result", result, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    run_op("illegal", 3'b111, 8'hAB, 8'hCD);
    run_op("nand ff", 3'b000, 8'hFF, 8'hFF);

    // Random ops against the reference model.
    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
